// File: rtl/sumador.sv
// Registered two's-complement adder slice built from rippled 4-bit carry-lookahead groups.
// Define SUMADOR_FLAGS_EN to build the C/V/N/Z flag registers; otherwise the flags read 0.
module sumador #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             out_valid,
    output logic             C,
    output logic             V,
    output logic             N,
    output logic             Z
);

    localparam int unsigned NumGroups = (WIDTH + 3) / 4;
    localparam int unsigned PadW      = NumGroups * 4;

    logic [PadW-1:0] a_pad;
    logic [PadW-1:0] b_pad;
    logic [PadW-1:0] gen;
    logic [PadW-1:0] prop;
    logic [PadW:0]   carry;
    logic [PadW-1:0] sum_pad;
    logic [WIDTH-1:0] sum_d;

    logic [WIDTH-1:0] s_q;
    logic             valid_q;

    assign a_pad = PadW'(A);
    assign b_pad = PadW'(B);
    assign gen   = a_pad & b_pad;
    assign prop  = a_pad ^ b_pad;

    // Lookahead inside each 4-bit group; group carry-out ripples into the next group.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b0;
        for (int k = 0; k < int'(NumGroups); k++) begin
            carry[4*k+1] = gen[4*k] | (prop[4*k] & carry[4*k]);
            carry[4*k+2] = gen[4*k+1] | (prop[4*k+1] & gen[4*k])
                         | (prop[4*k+1] & prop[4*k] & carry[4*k]);
            carry[4*k+3] = gen[4*k+2] | (prop[4*k+2] & gen[4*k+1])
                         | (prop[4*k+2] & prop[4*k+1] & gen[4*k])
                         | (prop[4*k+2] & prop[4*k+1] & prop[4*k] & carry[4*k]);
            carry[4*k+4] = (gen[4*k+3] | (prop[4*k+3] & gen[4*k+2])
                         | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                         | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]))
                         | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & prop[4*k]
                            & carry[4*k]);
        end
    end

    assign sum_pad = prop ^ carry[PadW-1:0];
    assign sum_d   = sum_pad[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                s_q <= sum_d;
            end
        end
    end

    assign S         = s_q;
    assign out_valid = valid_q;

`ifdef SUMADOR_FLAGS_EN
    logic c_d, v_d, n_d, z_d;
    logic c_q, v_q, n_q, z_q;

    assign c_d = carry[WIDTH];
    assign v_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum_d[WIDTH-1] != A[WIDTH-1]);
    assign n_d = sum_d[WIDTH-1];
    assign z_d = (sum_d == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q <= 1'b0;
            v_q <= 1'b0;
            n_q <= 1'b0;
            z_q <= 1'b0;
        end else if (in_valid) begin
            c_q <= c_d;
            v_q <= v_d;
            n_q <= n_d;
            z_q <= z_d;
        end
    end

    assign C = c_q;
    assign V = v_q;
    assign N = n_q;
    assign Z = z_q;
`else
    logic unused_carry;
    assign unused_carry = ^carry[PadW:WIDTH];

    assign C = 1'b0;
    assign V = 1'b0;
    assign N = 1'b0;
    assign Z = 1'b0;
`endif

endmodule

// File: tb/tb_sumador.sv
// Randomized self-checking bench for sumador against an arithmetic reference model.
module tb_sumador;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] S;
    logic        out_valid;
    logic        C;
    logic        V;
    logic        N;
    logic        Z;

    int total = 0;
    int bad   = 0;

`ifdef SUMADOR_FLAGS_EN
    bit flags_on = 1'b1;
`else
    bit flags_on = 1'b0;
`endif

    // Reference state: what the outputs should show after the latest edge.
    logic [31:0] m_s;
    logic        m_c, m_v, m_n, m_z;

    sumador #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .S         (S),
        .out_valid (out_valid),
        .C         (C),
        .V         (V),
        .N         (N),
        .Z         (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_load(input logic [31:0] a, input logic [31:0] b);
        longint unsigned us;
        longint          ss;
        us  = 64'(a) + 64'(b);
        ss  = longint'($signed(a)) + longint'($signed(b));
        m_s = us[31:0];
        m_c = us[32];
        m_v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        m_n = m_s[31];
        m_z = (m_s == 32'd0);
    endtask

    task automatic check_all(input string tag, input bit exp_valid);
        check_eq({tag, ".S"}, S, m_s);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'(exp_valid));
        check_eq({tag, ".C"}, 32'(C), 32'(m_c & flags_on));
        check_eq({tag, ".V"}, 32'(V), 32'(m_v & flags_on));
        check_eq({tag, ".N"}, 32'(N), 32'(m_n & flags_on));
        check_eq({tag, ".Z"}, 32'(Z), 32'(m_z & flags_on));
    endtask

    // Drive one cycle at the falling edge, then check 1 time unit after the rising edge.
    task automatic step(input string tag, input bit rst, input bit vld,
                        input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        rst_n    = rst;
        in_valid = vld;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
        if (!rst) begin
            m_s = '0; m_c = 1'b0; m_v = 1'b0; m_n = 1'b0; m_z = 1'b0;
        end else if (vld) begin
            model_load(a, b);
        end
        check_all(tag, rst && vld);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        m_s = '0; m_c = 1'b0; m_v = 1'b0; m_n = 1'b0; m_z = 1'b0;

        step("rst0", 1'b0, 1'b1, 32'd5, 32'd7);
        step("rst1", 1'b0, 1'b1, 32'd5, 32'd7);
        step("first", 1'b1, 1'b1, 32'd5, 32'd7);
        check_eq("first_sum", S, 32'd12);

        step("plain", 1'b1, 1'b1, 32'd100, 32'd20);
        check_eq("plain_sum", S, 32'h0000_0078);
        step("neg", 1'b1, 1'b1, 32'hFFFF_FFE7, 32'd20);
        check_eq("neg_sum", S, 32'hFFFF_FFFB);
        step("sub", 1'b1, 1'b1, 32'd80, 32'hFFFF_FFE7);
        check_eq("sub_sum", S, 32'h0000_0037);
        step("ovf", 1'b1, 1'b1, 32'h7FFF_FFFF, 32'd1);
        check_eq("ovf_sum", S, 32'h8000_0000);
        step("zero", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1);
        check_eq("zero_sum", S, 32'h0000_0000);
        step("negovf", 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000);

        step("str0", 1'b1, 1'b1, 32'd1, 32'd2);
        step("str1", 1'b1, 1'b1, 32'd1000, 32'd2000);
        step("str2", 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b1, 1'b0, $urandom(), $urandom());
        end
        check_eq("hold_sum", S, 32'hF0E2_1567);

        // Reset must discard an operation presented on the same edge.
        step("pre_rst", 1'b1, 1'b1, 32'd9, 32'd9);
        step("mid_rst", 1'b0, 1'b1, 32'd3, 32'd4);
        step("post_rst", 1'b1, 1'b0, 32'd3, 32'd4);

        for (int i = 0; i < 400; i++) begin
            bit rst;
            bit vld;
            rst = ($urandom_range(0, 49) != 0);
            vld = ($urandom_range(0, 3) != 0);
            step("rand", rst, vld, pick_operand(), pick_operand());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
